rgb_to_gray_stream: RTL and testbench

Streaming, parametrised RGB-to-grayscale converter for the camera-to-VGA processing chain. It sits between the pixel capture/buffer stage and the downstream filter/VGA stages. It accepts RGB565 or RGB888 pixels over a valid/ready handshake and passes frame sideband (start-of-frame, end-of-line) alongside each pixel. It provides four runtime-selectable luma modes, latched per frame, through a 3-stage pipeline with full backpressure.

---
 rtl/rgb_to_gray_stream.sv | 154 +++++++++++++++
 tb/tb_rgb_to_gray_stream.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_gray_stream.sv
// Streaming RGB565/RGB888 to grayscale converter: three register stages with
// valid/ready backpressure, per-frame luma mode and sof/eol sideband.
module rgb_to_gray_stream #(
    parameter int PIX_FMT = 0,
    parameter int OUT_W   = 8,
    localparam int PW     = (PIX_FMT != 0) ? 24 : 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    input  logic [PW-1:0]    in_pixel,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_gray,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_valid,
    input  logic             out_ready
);

    // Handshake: a word moves on a port in any cycle where valid and ready are
    // both high; a stage loads when it is empty or the next stage is loading.

    logic [7:0]  r_exp, g_exp, b_exp;
    logic [1:0]  mode_q;
    logic [1:0]  pix_mode;

    logic        s1_valid, s1_sof, s1_eol;
    logic [1:0]  s1_mode;
    logic [7:0]  s1_r, s1_g, s1_b;

    logic        s2_valid, s2_sof, s2_eol;
    logic [1:0]  s2_mode;
    logic [17:0] s2_t0;
    logic [15:0] s2_t1, s2_t2;

    logic        ld1, ld2, ld3;
    logic [17:0] t0_d;
    logic [15:0] t1_d, t2_d;
    logic [18:0] sum3;
    logic [18:0] full3;
    logic [7:0]  gray8;

    generate
        if (PIX_FMT != 0) begin : g_rgb888
            assign r_exp = in_pixel[23:16];
            assign g_exp = in_pixel[15:8];
            assign b_exp = in_pixel[7:0];
        end else begin : g_rgb565
            // Replicating the top bits makes full-scale channels reach 255.
            assign r_exp = {in_pixel[15:11], in_pixel[15:13]};
            assign g_exp = {in_pixel[10:5], in_pixel[10:9]};
            assign b_exp = {in_pixel[4:0], in_pixel[4:2]};
        end
    endgenerate

    assign ld3      = !out_valid || out_ready;
    assign ld2      = !s2_valid || ld3;
    assign ld1      = !s1_valid || ld2;
    assign in_ready = ld1;
    assign pix_mode = in_sof ? cfg_mode : mode_q;

    always_comb begin
        t0_d = '0;
        t1_d = '0;
        t2_d = '0;
        case (s1_mode)
            2'd0: begin
                t0_d = 18'(s1_r >> 2);
                t1_d = 16'(s1_g >> 1);
                t2_d = 16'(s1_b >> 3);
            end
            2'd1: begin
                t0_d = 18'(s1_r) * 18'd77;
                t1_d = 16'(s1_g) * 16'd150;
                t2_d = 16'(s1_b) * 16'd29;
            end
            2'd2: t0_d = (18'(s1_r) + 18'(s1_g) + 18'(s1_b)) * 18'd171;
            default: t0_d = 18'(s1_g);
        endcase
    end

    always_comb begin
        sum3  = 19'(s2_t0) + 19'(s2_t1) + 19'(s2_t2);
        full3 = sum3;
        case (s2_mode)
            2'd1:    full3 = (sum3 + 19'd128) >> 8;
            2'd2:    full3 = sum3 >> 9;
            default: full3 = sum3;
        endcase
        gray8 = (full3 > 19'd255) ? 8'hFF : full3[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= 2'd0;
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_eol    <= 1'b0;
            s1_mode   <= 2'd0;
            s1_r      <= 8'd0;
            s1_g      <= 8'd0;
            s1_b      <= 8'd0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_eol    <= 1'b0;
            s2_mode   <= 2'd0;
            s2_t0     <= 18'd0;
            s2_t1     <= 16'd0;
            s2_t2     <= 16'd0;
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else begin
            if (in_valid && ld1 && in_sof) begin
                mode_q <= cfg_mode;
            end
            if (ld1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sof  <= in_sof;
                    s1_eol  <= in_eol;
                    s1_mode <= pix_mode;
                    s1_r    <= r_exp;
                    s1_g    <= g_exp;
                    s1_b    <= b_exp;
                end
            end
            if (ld2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sof  <= s1_sof;
                    s2_eol  <= s1_eol;
                    s2_mode <= s1_mode;
                    s2_t0   <= t0_d;
                    s2_t1   <= t1_d;
                    s2_t2   <= t2_d;
                end
            end
            if (ld3) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_sof  <= s2_sof;
                    out_eol  <= s2_eol;
                    out_gray <= gray8[7 -: OUT_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_gray_stream.sv
// Directed bench for rgb_to_gray_stream: an RGB565/8-bit instance for most
// scenarios and an RGB888/4-bit instance for the narrow-output case.
module tb_rgb_to_gray_stream;

    logic        clk;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [15:0] in_pixel;
    logic        in_sof, in_eol, in_valid, in_ready;
    logic [7:0]  out_gray;
    logic        out_sof, out_eol, out_valid, out_ready;

    logic [1:0]  cfg_mode_b;
    logic [23:0] in_pixel_b;
    logic        in_sof_b, in_eol_b, in_valid_b, in_ready_b;
    logic [3:0]  out_gray_b;
    logic        out_sof_b, out_eol_b, out_valid_b, out_ready_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_gray_q[$];
    logic       got_sof_q[$];
    logic       got_eol_q[$];
    logic [7:0] exp_q[$];

    rgb_to_gray_stream #(.PIX_FMT(0), .OUT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .in_pixel(in_pixel),
        .in_sof(in_sof), .in_eol(in_eol), .in_valid(in_valid), .in_ready(in_ready),
        .out_gray(out_gray), .out_sof(out_sof), .out_eol(out_eol),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    rgb_to_gray_stream #(.PIX_FMT(1), .OUT_W(4)) dut_b (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode_b), .in_pixel(in_pixel_b),
        .in_sof(in_sof_b), .in_eol(in_eol_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_gray(out_gray_b), .out_sof(out_sof_b), .out_eol(out_eol_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: a word presented with out_ready high transfers at the next edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_gray_q.push_back(out_gray);
            got_sof_q.push_back(out_sof);
            got_eol_q.push_back(out_eol);
        end
    end

    task automatic clear_queues();
        got_gray_q.delete();
        got_sof_q.delete();
        got_eol_q.delete();
        exp_q.delete();
    endtask

    // Driver: present one pixel and hold it until accepted; returns just after the capture edge.
    task automatic send(input logic [15:0] pix, input logic sof, input logic eol,
                        input logic [1:0] mode);
        int cnt;
        in_pixel = pix;
        in_sof   = sof;
        in_eol   = eol;
        cfg_mode = mode;
        in_valid = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b, required 1 within 50 cycles", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eol   = 1'b0;
    endtask

    task automatic wait_outputs(input int n, output bit ok);
        int cnt;
        cnt = 0;
        while (got_gray_q.size() < n && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        ok = (got_gray_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++; if (out_gray !== 8'd0) begin errors++; $display("FAIL reset_out_gray: got %0d, required 0", out_gray); end
        checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL reset_out_sof: got %b, required 0", out_sof); end
        checks++; if (out_eol !== 1'b0) begin errors++; $display("FAIL reset_out_eol: got %b, required 0", out_eol); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_latency_mode1();
        clear_queues();
        out_ready = 1'b1;
        cfg_mode = 2'd1; in_pixel = 16'hFFFF; in_sof = 1'b1; in_eol = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_pixel = 16'hF800; in_sof = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_n1_valid: got %b, required 0", out_valid); end
        @(posedge clk); #1;
        in_pixel = 16'h0000; in_eol = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_n2_valid: got %b, required 0", out_valid); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_eol = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_n3_valid: got %b, required 1", out_valid); end
        checks++; if (out_gray !== 8'd255) begin errors++; $display("FAIL lat_n3_gray: got %0d, required 255", out_gray); end
        checks++; if (out_sof !== 1'b1) begin errors++; $display("FAIL lat_n3_sof: got %b, required 1", out_sof); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_gray !== 8'd77) begin errors++; $display("FAIL lat_n4_gray: got %0d, required 77", out_gray); end
        checks++; if (out_sof !== 1'b0) begin errors++; $display("FAIL lat_n4_sof: got %b, required 0", out_sof); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_gray !== 8'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL lat_n5_gray: got %0d valid %b, required 0 valid 1", out_gray, out_valid); end
        checks++; if (out_eol !== 1'b1) begin errors++; $display("FAIL lat_n5_eol: got %b, required 1", out_eol); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_n6_valid: got %b, required 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        bit ok;
        clear_queues();
        out_ready = 1'b1;
        send(16'hFFFF, 1'b1, 1'b0, 2'd0);
        send(16'h07E0, 1'b1, 1'b0, 2'd2);
        send(16'h07E0, 1'b1, 1'b1, 2'd3);
        wait_outputs(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL modes_count: got %0d outputs, required 3", got_gray_q.size());
        end else begin
            checks++; if (got_gray_q[0] !== 8'd221) begin errors++; $display("FAIL mode0_white: got %0d, required 221", got_gray_q[0]); end
            checks++; if (got_gray_q[1] !== 8'd85) begin errors++; $display("FAIL mode2_green: got %0d, required 85", got_gray_q[1]); end
            checks++; if (got_gray_q[2] !== 8'd255) begin errors++; $display("FAIL mode3_green: got %0d, required 255", got_gray_q[2]); end
            checks++; if (got_eol_q[2] !== 1'b1) begin errors++; $display("FAIL modes_eol: got %b, required 1", got_eol_q[2]); end
        end
    endtask

    task automatic test_mode_latch();
        bit ok;
        clear_queues();
        out_ready = 1'b1;
        send(16'hFFFF, 1'b1, 1'b0, 2'd1);
        send(16'hF800, 1'b0, 1'b0, 2'd2);
        send(16'hF800, 1'b1, 1'b0, 2'd2);
        wait_outputs(3, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL latch_count: got %0d outputs, required 3", got_gray_q.size());
        end else begin
            checks++; if (got_gray_q[0] !== 8'd255) begin errors++; $display("FAIL latch_sof_pix: got %0d, required 255", got_gray_q[0]); end
            checks++; if (got_gray_q[1] !== 8'd77) begin errors++; $display("FAIL latch_midframe: got %0d, required 77", got_gray_q[1]); end
            checks++; if (got_gray_q[2] !== 8'd85) begin errors++; $display("FAIL latch_next_sof: got %0d, required 85", got_gray_q[2]); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pix [6];
        logic        eolv [6];
        int acc, guard;
        bit ok;
        pix  = '{16'h07E0, 16'hFC00, 16'h021F, 16'h0020, 16'h0540, 16'h02A0};
        eolv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        clear_queues();
        exp_q = '{8'd255, 8'd130, 8'd65, 8'd4, 8'd170, 8'd85};
        out_ready = 1'b0;
        acc = 0;
        cfg_mode = 2'd3; in_pixel = pix[0]; in_sof = 1'b1; in_eol = eolv[0]; in_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
            in_pixel = pix[acc]; in_sof = (acc == 0); in_eol = eolv[acc];
        end
        @(negedge clk);
        checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepted: got %0d, required 3", acc); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_gray !== 8'd255) begin errors++; $display("FAIL bp_hold: got valid %b gray %0d, required 1 255", out_valid, out_gray); end
        checks++; if (got_gray_q.size() != 0) begin errors++; $display("FAIL bp_no_emit: got %0d outputs, required 0", got_gray_q.size()); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b, required 1", in_ready); end
        guard = 0;
        while (acc < 6 && guard < 50) begin
            if (in_ready) acc++;
            @(posedge clk); #1;
            if (acc < 6) begin
                in_pixel = pix[acc]; in_sof = 1'b0; in_eol = eolv[acc];
                @(negedge clk);
            end else begin
                in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
            end
            guard++;
        end
        in_valid = 1'b0;
        wait_outputs(6, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_count: got %0d outputs, required 6", got_gray_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_gray_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_gray[%0d]: got %0d, required %0d", i, got_gray_q[i], exp_q[i]); end
                checks++;
                if (got_eol_q[i] !== eolv[i]) begin errors++; $display("FAIL bp_eol[%0d]: got %b, required %b", i, got_eol_q[i], eolv[i]); end
            end
            checks++; if (got_sof_q[0] !== 1'b1) begin errors++; $display("FAIL bp_sof: got %b, required 1", got_sof_q[0]); end
        end
    endtask

    task automatic test_reset_midstream();
        bit ok;
        clear_queues();
        out_ready = 1'b1;
        send(16'hFFFF, 1'b1, 1'b0, 2'd1);
        send(16'hFFFF, 1'b1, 1'b0, 2'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
        checks++; if (out_gray !== 8'd0) begin errors++; $display("FAIL rstmid_gray: got %0d, required 0", out_gray); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, required 1", in_ready); end
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (got_gray_q.size() != 0) begin errors++; $display("FAIL rstmid_stale: got %0d outputs, required 0", got_gray_q.size()); end
        send(16'hFFFF, 1'b0, 1'b1, 2'd1);
        wait_outputs(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rstmid_count: got %0d outputs, required 1", got_gray_q.size());
        end else begin
            checks++; if (got_gray_q[0] !== 8'd221) begin errors++; $display("FAIL rstmid_mode0: got %0d, required 221", got_gray_q[0]); end
        end
    endtask

    task automatic test_rgb888_narrow();
        int cnt;
        out_ready_b = 1'b1;
        cfg_mode_b = 2'd1; in_pixel_b = 24'hFF0000; in_sof_b = 1'b1; in_eol_b = 1'b1; in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0; in_sof_b = 1'b0; in_eol_b = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (!out_valid_b && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (out_valid_b !== 1'b1) begin
            errors++; $display("FAIL rgb888_valid: got %b, required 1 within 20 cycles", out_valid_b);
        end else begin
            checks++; if (out_gray_b !== 4'h4) begin errors++; $display("FAIL rgb888_gray: got %0h, required 4", out_gray_b); end
            checks++; if (out_sof_b !== 1'b1 || out_eol_b !== 1'b1) begin errors++; $display("FAIL rgb888_flags: got sof %b eol %b, required 1 1", out_sof_b, out_eol_b); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        cfg_mode = 2'd0; in_pixel = '0; in_sof = 1'b0; in_eol = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cfg_mode_b = 2'd0; in_pixel_b = '0; in_sof_b = 1'b0; in_eol_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
        test_reset();
        test_latency_mode1();
        test_modes();
        test_mode_latch();
        test_backpressure();
        test_reset_midstream();
        test_rgb888_narrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
